// File: rtl/axi_lite_intr_ctrl.sv
// ---------------------------------------------------------------------------
// axi_lite_intr_ctrl
//
// AXI4-Lite slave interrupt controller. Up to 32 asynchronous interrupt
// sources are synchronised, turned into events (rising edge or level, per
// source), and latched into a sticky status register (ISR). Pending
// interrupts (IPR = ISR & IER) are gated by the global enable (GIER[0]) to
// drive one registered irq line towards the processor.
//
// Register map (byte offsets, bits [4:2] of the address decode):
//   0x00 GIER  RW  bit 0 = global interrupt enable
//   0x04 IER   RW  per-source enable
//   0x08 ISR   RO  sticky status
//   0x0C IAR   WO  write-1-to-clear ISR, reads 0
//   0x10 IPR   RO  ISR & IER
//   0x14-0x1C  reserved: read 0, writes dropped
//
// Ports:
//   ACLK, ARESETN     clock, asynchronous active-low reset
//   intr              raw interrupt sources (asynchronous to ACLK)
//   irq               interrupt request, C_IRQ_ACTIVE_STATE when asserted
//   s_axi_aw*/w*/b*   AXI4-Lite write address / data / response channels
//   s_axi_ar*/r*      AXI4-Lite read address / data channels
//   *prot             accepted and ignored; all responses are OKAY
// ---------------------------------------------------------------------------
module axi_lite_intr_ctrl #(
  parameter int unsigned C_S_AXI_DATA_WIDTH  = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH  = 5,
  parameter int unsigned C_NUM_OF_INTR       = 1,
  parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFF_FFFF,
  parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFF_FFFF,
  parameter bit          C_IRQ_ACTIVE_STATE  = 1'b1,
  parameter int unsigned C_SYNC_STAGES       = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_NUM_OF_INTR-1:0]        intr,
  output logic                            irq,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  // Bits at or above C_NUM_OF_INTR do not exist: they read 0 and ignore writes.
  localparam logic [31:0] INTR_MASK = (C_NUM_OF_INTR >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << C_NUM_OF_INTR) - 32'd1);

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

  // -------------------------------------------------------------------------
  // Interrupt source path
  // -------------------------------------------------------------------------
  logic [31:0]                    intr_ext;
  logic [C_SYNC_STAGES-1:0][31:0] sync_q, sync_d;
  logic [31:0]                    hist_q, hist_d;
  logic [31:0]                    sync_out;
  logic [31:0]                    evt;

  // Sources are normalised to active-high before the synchroniser so that
  // reset value 0 always means "inactive", whatever the source polarity.
  always_comb begin
    intr_ext = '0;
    intr_ext[C_NUM_OF_INTR-1:0] = intr;
  end

  always_comb begin
    sync_d[0] = (intr_ext ^ ~C_INTR_ACTIVE_STATE) & INTR_MASK;
    for (int i = 1; i < C_SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_out = sync_q[C_SYNC_STAGES-1];
  assign hist_d   = sync_out;

  // Edge sources fire once per rising edge; level sources fire every cycle
  // they are active, so ISR re-sets after a clear while the source holds.
  assign evt = (C_INTR_SENSITIVITY & sync_out & ~hist_q)
             | (~C_INTR_SENSITIVITY & sync_out);

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_e    w_state_q, w_state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic        wr_fire;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [31:0] wr_mask;

  assign wr_sel  = s_axi_awaddr[4:2];
  assign wr_data = s_axi_wdata;

  // Per-byte write enable expanded from wstrb.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wr_mask
    assign wr_mask[gi*8 +: 8] = {8{s_axi_wstrb[gi]}};
  end

  // The ready pulse is registered: both valids seen in IDLE raise
  // awready/wready for exactly one cycle, and the transfer commits at the
  // edge closing that cycle.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    wr_fire   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awready_q) begin
          if (s_axi_awvalid && s_axi_wvalid) begin
            wr_fire   = 1'b1;
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
          end
        end else if (s_axi_awvalid && s_axi_wvalid) begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers and irq
  // -------------------------------------------------------------------------
  logic        gier_q, gier_d;
  logic [31:0] ier_q, ier_d;
  logic [31:0] isr_q, isr_d;
  logic [31:0] iar_clr;
  logic [31:0] ipr;
  logic        irq_q, irq_d;

  always_comb begin
    gier_d  = gier_q;
    ier_d   = ier_q;
    iar_clr = '0;
    if (wr_fire) begin
      case (wr_sel)
        3'd0: if (s_axi_wstrb[0]) gier_d = wr_data[0];
        3'd1: ier_d   = ((ier_q & ~wr_mask) | (wr_data & wr_mask)) & INTR_MASK;
        3'd3: iar_clr = wr_data & wr_mask & INTR_MASK;
        default: ;
      endcase
    end
    // A new event in the same cycle as a clear wins so no event is lost.
    isr_d = ((isr_q & ~iar_clr) | evt) & INTR_MASK;
  end

  assign ipr   = isr_q & ier_q;
  assign irq_d = (gier_q && (|ipr)) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[4:2])
      3'd0:    rd_mux = {31'd0, gier_q};
      3'd1:    rd_mux = ier_q;
      3'd2:    rd_mux = isr_q;
      3'd4:    rd_mux = ipr;
      default: rd_mux = '0;
    endcase
  end

  // rdata is only loaded on the address handshake, so it stays stable for
  // as long as the master stalls rready.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q) begin
          if (s_axi_arvalid) begin
            rdata_d   = rd_mux;
            rvalid_d  = 1'b1;
            r_state_d = R_DATA;
          end
        end else if (s_axi_arvalid) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync_q    <= '0;
      hist_q    <= '0;
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      gier_q    <= 1'b0;
      ier_q     <= '0;
      isr_q     <= '0;
      irq_q     <= ~C_IRQ_ACTIVE_STATE;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      gier_q    <= gier_d;
      ier_q     <= ier_d;
      isr_q     <= isr_d;
      irq_q     <= irq_d;
    end
  end

  assign irq           = irq_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

endmodule
